hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised, stateful successor to the combinational load-use/branch hazard detector.
//  Per-register countdown scoreboard: each in-flight write records the cycles until its
//  result is forwardable. ID-stage rs/rt are checked against it every cycle.
//  Covers any ALU/load latency, EX-use and ID-use (branch compare) consumers, pipeline hold,
//  and a saturating stall-cycle counter.
//  Sits beside the ID stage; drives PC/IF_ID write-enable and ID_EX bubble insertion.
// PARAMETERS
//  REG_AW    5   register address width; NUM_REGS = 2**REG_AW, reg 0 never tracked
//  ALU_LAT   1   cycles after issue until an ALU result is forwardable into EX (>=1)
//  LOAD_LAT  2   same for load results (>= ALU_LAT)
//  STAT_W    32  width of stall-cycle counter
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  id_valid      in   1         ID holds a real instruction
//  id_rs         in   REG_AW    source reg A
//  id_rt         in   REG_AW    source reg B
//  id_use_rs     in   1         instruction reads rs
//  id_use_rt     in   1         instruction reads rt
//  id_branch     in   1         operands consumed in ID (BEQ/BNE compare)
//  id_flush      in   1         ID instruction squashed this cycle, must not issue
//  id_reg_write  in   1         ID instruction writes id_rd
//  id_mem_read   in   1         ID instruction is a load
//  id_rd         in   REG_AW    destination reg
//  hold          in   1         global pipeline freeze (e.g. memory wait)
//  stat_clr      in   1         synchronous clear of stall_cycles
//  stall         out  1         freeze PC/IF_ID, bubble into ID_EX
//  stall_cause   out  2         00 none, 01 load-use (EX), 10 branch-on-ALU, 11 branch-on-load
//  pending       out  NUM_REGS  bit r = cnt[r]!=0 (debug)
//  stall_cycles  out  STAT_W    saturating count of cycles with stall=1 and hold=0
// BEHAVIOUR
//  State: per reg r (1..NUM_REGS-1): cnt[r], width clog2(LOAD_LAT+1); ld[r] = producer is a load.
//  Reset (async, rst_n=0): all cnt=0, ld=0, stall_cycles=0.
//   Hence stall=0, stall_cause=00, pending=0.
//  Hazard per used source s (s!=0, use bit set), combinational from regs + ID inputs:
//   - EX consumer (id_branch=0): hazard if cnt[s] > 1.
//   - ID consumer (id_branch=1): hazard if cnt[s] != 0.
//  stall = id_valid & (hazard_rs | hazard_rt); flush does not mask stall.
//  Cause priority: rs before rt.
//   - id_branch=0 -> 01.
//   - id_branch=1 -> ld[s] ? 11 : 10.
//  issue = id_valid & ~stall & ~hold & ~id_flush & id_reg_write & (id_rd!=0).
//  Update each clk when hold=0:
//   - every cnt!=0 decrements by 1, saturating at 0;
//   - then on issue: cnt[id_rd] = id_mem_read ? LOAD_LAT : ALU_LAT, ld[id_rd] = id_mem_read.
//     Issue overrides the decrement on the same reg (WAW: newest wins).
//  hold=1: cnt/ld frozen, no issue. stall still evaluated combinationally, stall_cycles not incremented.
//  stall_cycles: stat_clr wins -> 0; else +1 when stall & ~hold, saturating at all-ones.
//  Default latencies reproduce the classic 5-stage rules:
//   - load-use: 1 bubble.
//   - branch after ALU: 1 bubble.
//   - branch after load: 2 bubbles.
//   - ALU->ALU: 0 bubbles.
//  Reset mid-operation clears all state immediately; no pending write survives.
//  Writes to reg 0 and id_use_*=0 operands never create or detect hazards.
// TESTING
//  1. lw r8 issue; next cycle add r9,r8 (EX use) -> stall=1 cause=01 one cycle, then 0.
//  2. add r3 issue; next cycle beq r3,r4 -> stall=1 cause=10 one cycle; add->add r3 -> no stall.
//  3. lw r5 then beq r5 -> stall 2 cycles, cause=11 both; stall_cycles 0 -> 2.
//  4. lw r6, then hold=1 for 3 cycles with add r7,r6 in ID.
//     -> stall stays 1, cnt[r6] frozen at 2, stall_cycles unchanged.
//     -> after hold drops, exactly 1 more stall cycle.
//  5. lw r0 / id_flush=1 on lw r10 -> next-cycle consumer of r0/r10 sees no stall, pending=0.
//  6. LOAD_LAT=4, ALU_LAT=2: lw r2, then dependent add r11,r2 -> 3 stall cycles.
//     Assert rst_n=0 mid-stall -> stall=0 and pending=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for ID-stage hazard detection: each in-flight write
// counts down to the cycle its result becomes forwardable, and ID sources are checked against it.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int STAT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_branch,
    input  logic                   id_flush,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   hold,
    input  logic                   stat_clr,
    output logic                   stall,
    output logic [1:0]             stall_cause,
    output logic [2**REG_AW-1:0]   pending,
    output logic [STAT_W-1:0]      stall_cycles
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int CW       = $clog2(LOAD_LAT + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ld;
    logic                hz_rs;
    logic                hz_rt;
    logic                issue;

    // An EX consumer can take the value via forwarding once cnt reaches 1; an ID
    // consumer (branch compare) has no forwarding path, so it needs cnt at 0.
    always_comb begin
        hz_rs = 1'b0;
        hz_rt = 1'b0;
        if (id_use_rs && id_rs != '0)
            hz_rs = id_branch ? (cnt[id_rs] != '0) : (cnt[id_rs] > ONE);
        if (id_use_rt && id_rt != '0)
            hz_rt = id_branch ? (cnt[id_rt] != '0) : (cnt[id_rt] > ONE);
    end

    assign stall = id_valid & (hz_rs | hz_rt);
    assign issue = id_valid & ~stall & ~hold & ~id_flush & id_reg_write & (id_rd != '0);

    always_comb begin
        stall_cause = 2'b00;
        if (stall) begin
            if (!id_branch)
                stall_cause = 2'b01;
            else if (hz_rs)
                stall_cause = ld[id_rs] ? 2'b11 : 2'b10;
            else
                stall_cause = ld[id_rt] ? 2'b11 : 2'b10;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NUM_REGS; r++)
            pending[r] = (cnt[r] != '0);
    end

    // Register 0 is hardwired to zero, so its entry stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            ld <= '0;
        end else if (!hold) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && id_rd == REG_AW'(r)) begin
                    cnt[r] <= id_mem_read ? LOAD_CNT : ALU_CNT;
                    ld[r]  <= id_mem_read;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stat_clr)
            stall_cycles <= '0;
        else if (stall && !hold && stall_cycles != '1)
            stall_cycles <= stall_cycles + STAT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one default-latency instance and one with long
// latencies and a 2-bit stall counter, sharing the same ID-stage stimulus.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt, id_branch, id_flush;
    logic        id_reg_write, id_mem_read, hold, stat_clr;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        stall,  stall6;
    logic [1:0]  cause,  cause6;
    logic [31:0] pending, pending6;
    logic [31:0] cycles;
    logic [1:0]  cycles6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic       stall;
        logic [1:0] cause;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_flush(id_flush), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rd(id_rd), .hold(hold), .stat_clr(stat_clr), .stall(stall),
        .stall_cause(cause), .pending(pending), .stall_cycles(cycles)
    );

    hazard_scoreboard #(.REG_AW(5), .ALU_LAT(2), .LOAD_LAT(4), .STAT_W(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_flush(id_flush), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rd(id_rd), .hold(hold), .stat_clr(stat_clr), .stall(stall6),
        .stall_cause(cause6), .pending(pending6), .stall_cycles(cycles6)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pops the oldest expectation and compares it against the selected instance.
    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        if (e.sel) begin
            checkValue({e.tag, "_stall"}, 32'(stall6), 32'(e.stall));
            checkValue({e.tag, "_cause"}, 32'(cause6), 32'(e.cause));
        end else begin
            checkValue({e.tag, "_stall"}, 32'(stall), 32'(e.stall));
            checkValue({e.tag, "_cause"}, 32'(cause), 32'(e.cause));
        end
    endtask

    // Inputs are already driven; queue the expectation, check at negedge, then cross the clock edge.
    task automatic applyStimulus(input string tag, input bit sel, input logic es, input logic [1:0] ec);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.stall = es;
        e.cause = ec;
        exp_q.push_back(e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic br,
                            input logic rw, input logic mr, input logic [4:0] rd);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_branch    = br;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_rd        = rd;
    endtask

    task automatic setAlu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        setInstr(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rd);
    endtask

    task automatic setLoad(input logic [4:0] rd, input logic [4:0] rs);
        setInstr(1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rd);
    endtask

    task automatic setBranch(input logic [4:0] rs, input logic [4:0] rt);
        setInstr(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic setNop();
        setInstr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        hold     = 1'b0;
        stat_clr = 1'b0;
        id_flush = 1'b0;
        setNop();
        #2;
        checkValue("reset_stall",   32'(stall), 32'd0);
        checkValue("reset_cause",   32'(cause), 32'd0);
        checkValue("reset_pending", pending,    32'd0);
        checkValue("reset_cycles",  cycles,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load followed by an EX consumer: one bubble.
        setLoad(5'd8, 5'd1);          applyStimulus("t1_lw",    0, 1'b0, 2'b00);
        setAlu(5'd9, 5'd8, 5'd2);     applyStimulus("t1_add_a", 0, 1'b1, 2'b01);
                                      applyStimulus("t1_add_b", 0, 1'b0, 2'b00);
        setNop();                     applyStimulus("t1_nop",   0, 1'b0, 2'b00);
        checkValue("t1_cycles", cycles, 32'd1);

        // Branch on an ALU result: one bubble; ALU to ALU needs none.
        setAlu(5'd3, 5'd1, 5'd2);     applyStimulus("t2_add",   0, 1'b0, 2'b00);
        setBranch(5'd3, 5'd4);        applyStimulus("t2_beq_a", 0, 1'b1, 2'b10);
                                      applyStimulus("t2_beq_b", 0, 1'b0, 2'b00);
        setAlu(5'd3, 5'd1, 5'd2);     applyStimulus("t2_add2",  0, 1'b0, 2'b00);
        setAlu(5'd12, 5'd3, 5'd1);    applyStimulus("t2_addadd", 0, 1'b0, 2'b00);
        setNop();                     applyStimulus("t2_nop",   0, 1'b0, 2'b00);
        checkValue("t2_cycles", cycles, 32'd2);

        // Branch on a load: two bubbles, counter cleared first.
        stat_clr = 1'b1;              applyStimulus("t3_clr",   0, 1'b0, 2'b00);
        stat_clr = 1'b0;
        checkValue("t3_cycles_clr", cycles, 32'd0);
        setLoad(5'd5, 5'd1);          applyStimulus("t3_lw",    0, 1'b0, 2'b00);
        setBranch(5'd5, 5'd4);        applyStimulus("t3_beq_a", 0, 1'b1, 2'b11);
                                      applyStimulus("t3_beq_b", 0, 1'b1, 2'b11);
                                      applyStimulus("t3_beq_c", 0, 1'b0, 2'b00);
        checkValue("t3_cycles", cycles, 32'd2);

        // Hold freezes the scoreboard and the stall counter while stall stays visible.
        setNop();                     applyStimulus("t4_gap",   0, 1'b0, 2'b00);
        setLoad(5'd6, 5'd1);          applyStimulus("t4_lw",    0, 1'b0, 2'b00);
        setAlu(5'd7, 5'd6, 5'd2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++)   applyStimulus("t4_hold",  0, 1'b1, 2'b01);
        checkValue("t4_cycles_held",  cycles,  32'd2);
        checkValue("t4_pending_held", pending, 32'h0000_0040);
        hold = 1'b0;                  applyStimulus("t4_rel_a", 0, 1'b1, 2'b01);
                                      applyStimulus("t4_rel_b", 0, 1'b0, 2'b00);
        setNop();                     applyStimulus("t4_nop",   0, 1'b0, 2'b00);
        checkValue("t4_cycles", cycles, 32'd3);

        // Writes to r0, flushed loads and unused operands never create hazards.
        setLoad(5'd0, 5'd1);          applyStimulus("t5_lw_r0",  0, 1'b0, 2'b00);
        setAlu(5'd9, 5'd0, 5'd0);     applyStimulus("t5_use_r0", 0, 1'b0, 2'b00);
        setLoad(5'd10, 5'd1);
        id_flush = 1'b1;              applyStimulus("t5_flush",  0, 1'b0, 2'b00);
        id_flush = 1'b0;
        setAlu(5'd11, 5'd10, 5'd10);
        checkValue("t5_pending", pending, 32'd0);
                                      applyStimulus("t5_use_r10", 0, 1'b0, 2'b00);
        setLoad(5'd13, 5'd1);         applyStimulus("t5_lw13",   0, 1'b0, 2'b00);
        setInstr(1'b1, 5'd13, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14);
                                      applyStimulus("t5_nouse",  0, 1'b0, 2'b00);
        setNop();                     applyStimulus("t5_nop",    0, 1'b0, 2'b00);

        // Long-latency instance: three bubbles, counter saturates, async reset clears at once.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        setLoad(5'd2, 5'd1);          applyStimulus("t6_lw",    1, 1'b0, 2'b00);
        setAlu(5'd11, 5'd2, 5'd1);
        for (int i = 0; i < 3; i++)   applyStimulus("t6_stall", 1, 1'b1, 2'b01);
                                      applyStimulus("t6_go",    1, 1'b0, 2'b00);
        setNop();                     applyStimulus("t6_nop_a", 1, 1'b0, 2'b00);
                                      applyStimulus("t6_nop_b", 1, 1'b0, 2'b00);
        checkValue("t6_cycles", 32'(cycles6), 32'd3);
        setLoad(5'd2, 5'd1);          applyStimulus("t6_lw2",   1, 1'b0, 2'b00);
        setAlu(5'd11, 5'd2, 5'd1);    applyStimulus("t6_stall2", 1, 1'b1, 2'b01);
        checkValue("t6_cycles_sat", 32'(cycles6), 32'd3);
        checkValue("t6_stall_pre",  32'(stall6),  32'd1);
        rst_n = 1'b0;
        #1;
        checkValue("t6_rst_stall",   32'(stall6), 32'd0);
        checkValue("t6_rst_pending", pending6,    32'd0);
        checkValue("t6_rst_cycles",  32'(cycles6), 32'd0);

        checkValue("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
